// File: rtl/alu_exec.sv
// ALU execution unit: single-cycle logic/arithmetic ops and a 16-step signed shift-add multiply.
// Latency is 1 cycle to o_done for simple ops and 17 cycles for MPY. i_start is ignored while o_busy is high.
module alu_exec #(
    parameter int WIDTH = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [3:0]       i_alu_op,
    input  logic [WIDTH-1:0] i_operand_a,
    input  logic [WIDTH-1:0] i_operand_b,
    output logic [WIDTH-1:0] o_result,
    output logic [WIDTH-1:0] o_result_hi,
    output logic [4:0]       o_flags,
    output logic             o_busy,
    output logic             o_done
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [3:0] OP_ADD = 4'd1, OP_SUB = 4'd2, OP_AND = 4'd3, OP_OR  = 4'd4,
                           OP_NOT = 4'd5, OP_SHL = 4'd6, OP_SHR = 4'd7, OP_MPY = 4'd8;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic               neg_q, neg_d;
    logic [WIDTH-1:0]   res_q, res_d, hi_q, hi_d;
    logic [4:0]         flags_q, flags_d;

    logic               accept;
    logic [WIDTH:0]     add_w, sub_w, step_sum;
    logic [WIDTH-1:0]   abs_a, abs_b, op_res;
    logic [2*WIDTH-1:0] step_acc, prod;
    logic               op_wr, op_cf, op_of;

    assign accept = i_start && (state_q != S_MUL);
    assign add_w  = {1'b0, i_operand_a} + {1'b0, i_operand_b};
    assign sub_w  = {1'b0, i_operand_a} - {1'b0, i_operand_b};
    // Magnitudes stay unsigned so that -2^(W-1) is representable
    assign abs_a  = i_operand_a[WIDTH-1] ? -i_operand_a : i_operand_a;
    assign abs_b  = i_operand_b[WIDTH-1] ? -i_operand_b : i_operand_b;

    // Multiplier sits in the low half of acc_q and is consumed LSB-first as the sum shifts in
    assign step_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
    assign step_acc = {step_sum, acc_q[WIDTH-1:1]};
    assign prod     = neg_q ? -step_acc : step_acc;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mcand_d = mcand_q;
        acc_d   = acc_q;
        neg_d   = neg_q;
        res_d   = res_q;
        hi_d    = hi_q;
        flags_d = flags_q;
        op_wr   = 1'b1;
        op_cf   = 1'b0;
        op_of   = 1'b0;
        op_res  = '0;

        case (i_alu_op)
            OP_ADD: begin
                op_res = add_w[WIDTH-1:0];
                op_cf  = add_w[WIDTH];
                op_of  = (i_operand_a[WIDTH-1] == i_operand_b[WIDTH-1]) &&
                         (add_w[WIDTH-1] != i_operand_a[WIDTH-1]);
            end
            OP_SUB: begin
                op_res = sub_w[WIDTH-1:0];
                op_cf  = sub_w[WIDTH];
                op_of  = (i_operand_a[WIDTH-1] != i_operand_b[WIDTH-1]) &&
                         (sub_w[WIDTH-1] != i_operand_a[WIDTH-1]);
            end
            OP_AND: op_res = i_operand_a & i_operand_b;
            OP_OR:  op_res = i_operand_a | i_operand_b;
            OP_NOT: op_res = ~i_operand_a;
            OP_SHL: begin
                op_res = {i_operand_a[WIDTH-2:0], 1'b0};
                op_cf  = i_operand_a[WIDTH-1];
            end
            OP_SHR: begin
                op_res = {i_operand_a[WIDTH-1], i_operand_a[WIDTH-1:1]};
                op_cf  = i_operand_a[0];
            end
            default: op_wr = 1'b0;
        endcase

        case (state_q)
            S_MUL: begin
                acc_d = step_acc;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH-1)) begin
                    {hi_d, res_d} = prod;
                    flags_d = {prod == '0, 1'b0,
                               prod[2*WIDTH-1:WIDTH] != {WIDTH{prod[WIDTH-1]}},
                               prod[2*WIDTH-1], 1'b1};
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
                if (accept) begin
                    state_d = S_DONE;
                    if (i_alu_op == OP_MPY) begin
                        mcand_d = abs_a;
                        acc_d   = {{WIDTH{1'b0}}, abs_b};
                        neg_d   = i_operand_a[WIDTH-1] ^ i_operand_b[WIDTH-1];
                        cnt_d   = '0;
                        state_d = S_MUL;
                    end else if (op_wr) begin
                        res_d   = op_res;
                        flags_d = {op_res == '0, op_cf, op_of, op_res[WIDTH-1], 1'b0};
                    end
                end
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            mcand_q <= '0;
            acc_q   <= '0;
            neg_q   <= 1'b0;
            res_q   <= '0;
            hi_q    <= '0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mcand_q <= mcand_d;
            acc_q   <= acc_d;
            neg_q   <= neg_d;
            res_q   <= res_d;
            hi_q    <= hi_d;
            flags_q <= flags_d;
        end
    end

    assign o_result    = res_q;
    assign o_result_hi = hi_q;
    assign o_flags     = flags_q;
    assign o_busy      = (state_q == S_MUL);
    assign o_done      = (state_q == S_DONE);
endmodule

// File: tb/tb_alu_exec.sv
// Directed-vector bench for alu_exec with hand-computed results and flags {ZF,CF,OF,NF,MF}.
module tb_alu_exec;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  op;
    logic [15:0] a, b;
    logic [15:0] result, result_hi;
    logic [4:0]  flags;
    logic        busy, done;

    int errors = 0;
    int checks = 0;
    int cyc;
    int busy_cnt;
    int done_seen;

    always #5 clk = ~clk;

    alu_exec #(.WIDTH(16)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_start     (start),
        .i_alu_op    (op),
        .i_operand_a (a),
        .i_operand_b (b),
        .o_result    (result),
        .o_result_hi (result_hi),
        .o_flags     (flags),
        .o_busy      (busy),
        .o_done      (done)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Presents an op for one edge; returns at the following negedge (cycle k+1).
    task automatic issue(input logic [3:0] o, input logic [15:0] va, input logic [15:0] vb);
        op = o; a = va; b = vb; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Call right after issue(); cyc counts cycles since the accept edge.
    task automatic wait_done();
        while (!done && cyc < 40) begin
            if (busy) busy_cnt++;
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic run_mpy(input string tag, input logic [15:0] va, input logic [15:0] vb,
                           input logic [15:0] ehi, input logic [15:0] elo, input logic [4:0] ef);
        issue(4'd8, va, vb);
        cyc = 1; busy_cnt = 0;
        wait_done();
        chk({tag, "_done_cyc"}, cyc, 17);
        chk({tag, "_busy_cnt"}, busy_cnt, 16);
        chk({tag, "_hi"}, result_hi, ehi);
        chk({tag, "_lo"}, result, elo);
        chk({tag, "_flags"}, flags, ef);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; op = 4'd0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        chk("rst_result", result, 0);
        chk("rst_hi", result_hi, 0);
        chk("rst_flags", flags, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        rst = 1'b0;
        @(negedge clk);

        // ADD overflow into sign bit
        issue(4'd1, 16'h7FFF, 16'h0001);
        chk("add_done", done, 1);
        chk("add_res", result, 16'h8000);
        chk("add_flags", flags, 5'b00110);

        // SUB to zero, then back-to-back SUB issued in the DONE cycle
        issue(4'd2, 16'h0005, 16'h0005);
        chk("sub0_done", done, 1);
        chk("sub0_res", result, 16'h0000);
        chk("sub0_flags", flags, 5'b10000);
        issue(4'd2, 16'h0003, 16'h0005);
        chk("sub1_done", done, 1);
        chk("sub1_res", result, 16'hFFFE);
        chk("sub1_flags", flags, 5'b01010);
        @(negedge clk);
        chk("idle_done", done, 0);

        run_mpy("mpy_neg", 16'hFFFD, 16'h0007, 16'hFFFF, 16'hFFEB, 5'b00011);
        run_mpy("mpy_ovf", 16'h4000, 16'h0004, 16'h0001, 16'h0000, 5'b00101);
        run_mpy("mpy_min", 16'h8000, 16'h8000, 16'h4000, 16'h0000, 5'b00101);

        issue(4'd6, 16'h8001, 16'h0000);
        chk("shl_res", result, 16'h0002);
        chk("shl_flags", flags, 5'b01000);
        issue(4'd7, 16'h8001, 16'h0000);
        chk("shr_res", result, 16'hC000);
        chk("shr_flags", flags, 5'b01010);
        issue(4'd5, 16'hFFFF, 16'h0000);
        chk("not_res", result, 16'h0000);
        chk("not_flags", flags, 5'b10000);
        chk("not_hi", result_hi, 16'h4000);
        issue(4'd12, 16'h1234, 16'h5678);
        chk("nop_done", done, 1);
        chk("nop_res", result, 16'h0000);
        chk("nop_flags", flags, 5'b10000);
        issue(4'd1, 16'h0001, 16'h0002);
        chk("add2_res", result, 16'h0003);
        chk("add2_hi", result_hi, 16'h4000);

        // Start pulsed at iteration 5 of a multiply must be ignored
        issue(4'd8, 16'h0003, 16'h0005);
        cyc = 1; busy_cnt = 0;
        repeat (5) begin
            if (busy) busy_cnt++;
            @(negedge clk);
            cyc++;
        end
        op = 4'd1; a = 16'h0001; b = 16'h0001; start = 1'b1;
        if (busy) busy_cnt++;
        @(negedge clk);
        cyc++;
        start = 1'b0;
        wait_done();
        chk("intr_done_cyc", cyc, 17);
        chk("intr_busy_cnt", busy_cnt, 16);
        chk("intr_lo", result, 16'h000F);
        chk("intr_hi", result_hi, 16'h0000);
        chk("intr_flags", flags, 5'b00001);

        // Reset at iteration 8 aborts the multiply
        issue(4'd8, 16'h1234, 16'h0002);
        repeat (7) @(negedge clk);
        chk("abort_busy_pre", busy, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_res", result, 0);
        chk("abort_hi", result_hi, 0);
        chk("abort_flags", flags, 0);
        chk("abort_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;
        done_seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        chk("abort_no_done", done_seen, 0);
        issue(4'd1, 16'h0002, 16'h0003);
        chk("post_add_done", done, 1);
        chk("post_add_res", result, 16'h0005);
        chk("post_add_flags", flags, 5'b00000);

        // Start coincident with reset: reset wins
        rst = 1'b1;
        issue(4'd1, 16'h0004, 16'h0004);
        rst = 1'b0;
        chk("rst_start_res", result, 0);
        chk("rst_start_done", done, 0);
        @(negedge clk);
        chk("rst_start_done2", done, 0);
        chk("rst_start_busy", busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
